// File: rtl/manta_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, execute redirect and the
// {pc, instruction} handshake towards decode.
interface manta_fetch_if #(
   parameter int ADDR_W = 16,
   parameter int INST_W = 16
);
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [INST_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      output imem_en, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_rdata, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_en, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_rdata, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/manta_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency instruction memory and
// buffers {pc, word} pairs in a small FIFO feeding decode; redirects flush everything.
module manta_fetch #(
   parameter int                ADDR_W     = 16,
   parameter int                INST_W     = 16,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input logic           clk,
   input logic           rst,
   manta_fetch_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 2;

   typedef enum logic [1:0] {BOOT, RUN, KILL} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] pc;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  occupancy;

   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;

   logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
   logic [INST_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   // A pop this cycle frees a slot before the new request's word lands, which is
   // what sustains one instruction per cycle with only two entries.
   assign pop       = bus.inst_valid && bus.inst_ready;
   assign occupancy = count + CNT_W'(vld_p1) - CNT_W'(pop);

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         BOOT: state_next = RUN;
         RUN, KILL: begin
            state_next = RUN;
            if (bus.redirect_valid) begin
               if (vld_p1) state_next = KILL;
            end else begin
               issue = (occupancy < CNT_W'(FIFO_DEPTH));
            end
         end
         default: state_next = BOOT;
      endcase
      if (rst) issue = 1'b0;
   end

   // Response word is written unless a redirect (or KILL) discards it.
   assign push = vld_p1 && !bus.redirect_valid && (state != KILL);

   assign bus.imem_en    = issue;
   assign bus.imem_addr  = pc;
   assign bus.inst_valid = (count != '0) && !rst;
   assign bus.inst_data  = fifo_data[rd_ptr];
   assign bus.inst_pc    = fifo_pc[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= BOOT;
         pc     <= RESET_PC;
         vld_p1 <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_next;
         vld_p1 <= issue;
         if (bus.redirect_valid) begin
            pc     <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (issue) pc     <= pc + ADDR_W'(1);
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Stage p1: address of the outstanding read, then the returned word into the FIFO.
   always_ff @(posedge clk) begin
      if (issue) addr_p1 <= pc;
      if (push) begin
         fifo_pc[wr_ptr]   <= addr_p1;
         fifo_data[wr_ptr] <= bus.imem_rdata;
      end
   end
endmodule

// File: tb/tb_manta_fetch.sv
// Directed bench for manta_fetch: reset, stream, back-pressure, redirects, PC wrap,
// mid-stream reset and a random ready/redirect run against a PC reference model.
module tb_manta_fetch;
   localparam int ADDR_W = 16;
   localparam int INST_W = 16;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   manta_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

   manta_fetch #(
      .ADDR_W(ADDR_W), .INST_W(INST_W), .FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Synchronous memory; garbage when not read so mistimed captures show up.
   always @(posedge clk)
      bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : 16'hDEAD;

   always @(negedge clk) begin
      if (!rst && int'(dut.count) > DEPTH) begin
         n_err++;
         $display("FAIL fifo_overflow: count=%0d limit=%0d", dut.count, DEPTH);
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      go(); rst = 1'b1; bus.redirect_valid = 1'b0;
      go(); rst = 1'b1;
      go(); rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] p;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         go();
         @(negedge clk);
         n_vec++;
         if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b valid=%b addr=%h, want 0 0 0000",
                     bus.imem_en, bus.inst_valid, bus.imem_addr);
         end
      end
      go(); rst = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) go();
         @(negedge clk);
         n_vec++;
         if (bus.imem_en !== (c >= 1) || (c >= 1 && bus.imem_addr !== 16'(c - 1))) begin
            n_err++;
            $display("FAIL stream_req c%0d: en=%b addr=%h, want en=%b addr=%h",
                     c, bus.imem_en, bus.imem_addr, (c >= 1), 16'(c - 1));
         end
         p = 16'(c - 3);
         n_vec++;
         if (bus.inst_valid !== (c >= 3) ||
             (c >= 3 && (bus.inst_pc !== p || bus.inst_data !== mem_word(p)))) begin
            n_err++;
            $display("FAIL stream_out c%0d: valid=%b pc=%h data=%h, want valid=%b pc=%h data=%h",
                     c, bus.inst_valid, bus.inst_pc, bus.inst_data, (c >= 3), p, mem_word(p));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] p;
      go(); bus.inst_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         if (s > 0) go();
         @(negedge clk);
         n_vec++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0004 ||
             bus.inst_data !== mem_word(16'h0004) || bus.imem_en !== 1'b0) begin
            n_err++;
            $display("FAIL stall s%0d: valid=%b pc=%h data=%h en=%b, want 1 0004 %h 0",
                     s, bus.inst_valid, bus.inst_pc, bus.inst_data, bus.imem_en, mem_word(16'h0004));
         end
      end
      go(); bus.inst_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) go();
         @(negedge clk);
         p = 16'(4 + k);
         n_vec++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== p || bus.inst_data !== mem_word(p)) begin
            n_err++;
            $display("FAIL resume k%0d: valid=%b pc=%h data=%h, want 1 %h %h",
                     k, bus.inst_valid, bus.inst_pc, bus.inst_data, p, mem_word(p));
         end
      end
   endtask

   task automatic test_redirect_inflight();
      logic [15:0] p;
      apply_reset();
      bus.inst_ready = 1'b1;
      repeat (7) go();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
      @(negedge clk);
      n_vec++;
      if (bus.imem_en !== 1'b0) begin
         n_err++; $display("FAIL redir_cycle_en: en=%b, want 0", bus.imem_en);
      end
      go(); bus.redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k > 0) go();
         @(negedge clk);
         n_vec++;
         if (bus.inst_valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 16'(16'h0040 + k)) begin
            n_err++;
            $display("FAIL redir_gap k%0d: valid=%b en=%b addr=%h, want 0 1 %h",
                     k, bus.inst_valid, bus.imem_en, bus.imem_addr, 16'(16'h0040 + k));
         end
      end
      for (int k = 0; k < 4; k++) begin
         go();
         @(negedge clk);
         p = 16'(16'h0040 + k);
         n_vec++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== p || bus.inst_data !== mem_word(p)) begin
            n_err++;
            $display("FAIL redir_stream k%0d: valid=%b pc=%h data=%h, want 1 %h %h",
                     k, bus.inst_valid, bus.inst_pc, bus.inst_data, p, mem_word(p));
         end
      end
   endtask

   task automatic test_wrap_back_to_back();
      logic [15:0] p;
      go(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h1234;
      @(negedge clk);
      go(); bus.redirect_pc = 16'hFFFE;
      @(negedge clk);
      n_vec++;
      if (bus.imem_en !== 1'b0) begin
         n_err++; $display("FAIL b2b_redir_en: en=%b, want 0", bus.imem_en);
      end
      go(); bus.redirect_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'hFFFE || bus.inst_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_last_wins: en=%b addr=%h valid=%b, want 1 fffe 0",
                  bus.imem_en, bus.imem_addr, bus.inst_valid);
      end
      go();
      for (int k = 0; k < 4; k++) begin
         go();
         @(negedge clk);
         p = 16'hFFFE + 16'(k);
         n_vec++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== p || bus.inst_data !== mem_word(p)) begin
            n_err++;
            $display("FAIL wrap k%0d: valid=%b pc=%h data=%h, want 1 %h %h",
                     k, bus.inst_valid, bus.inst_pc, bus.inst_data, p, mem_word(p));
         end
      end
   endtask

   task automatic test_boot_redirect();
      apply_reset();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
      @(negedge clk);
      n_vec++;
      if (bus.imem_en !== 1'b0) begin
         n_err++; $display("FAIL boot_no_req: en=%b, want 0", bus.imem_en);
      end
      go(); bus.redirect_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.imem_en !== 1'b1 || bus.imem_addr !== 16'h0100) begin
         n_err++;
         $display("FAIL boot_redir_req: en=%b addr=%h, want 1 0100", bus.imem_en, bus.imem_addr);
      end
      go(); go();
      @(negedge clk);
      n_vec++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0100 || bus.inst_data !== mem_word(16'h0100)) begin
         n_err++;
         $display("FAIL boot_redir_out: valid=%b pc=%h data=%h, want 1 0100 %h",
                  bus.inst_valid, bus.inst_pc, bus.inst_data, mem_word(16'h0100));
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] p;
      go(); bus.inst_ready = 1'b0;
      repeat (4) go();
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.inst_valid !== 1'b0 || bus.imem_en !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_during: valid=%b en=%b, want 0 0", bus.inst_valid, bus.imem_en);
      end
      go(); rst = 1'b0; bus.inst_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) go();
         @(negedge clk);
         p = 16'(c - 3);
         n_vec++;
         if (bus.inst_valid !== (c >= 3) ||
             (c >= 3 && (bus.inst_pc !== p || bus.inst_data !== mem_word(p))) ||
             (c == 0 && (bus.imem_en !== 1'b0 || bus.imem_addr !== 16'h0000))) begin
            n_err++;
            $display("FAIL midrst_restart c%0d: valid=%b pc=%h en=%b addr=%h, want valid=%b pc=%h",
                     c, bus.inst_valid, bus.inst_pc, bus.imem_en, bus.imem_addr, (c >= 3), p);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] exp_pc;
      int          delivered;
      exp_pc    = 16'h0000;
      delivered = 0;
      for (int i = 0; i < 1000; i++) begin
         go();
         bus.inst_ready     = 1'($urandom_range(0, 1));
         bus.redirect_valid = (i == 0) || ($urandom_range(0, 99) < 3);
         bus.redirect_pc    = 16'($urandom);
         @(negedge clk);
         if (bus.redirect_valid) begin
            exp_pc = bus.redirect_pc;
         end else if (bus.inst_valid && bus.inst_ready) begin
            n_vec++;
            delivered++;
            if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
               n_err++;
               $display("FAIL random cyc%0d: pc=%h data=%h, want %h %h",
                        i, bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 16'd1;
         end
      end
      go(); bus.redirect_valid = 1'b0;
      n_vec++;
      if (delivered < 200) begin
         n_err++; $display("FAIL random_progress: delivered=%0d, want >= 200", delivered);
      end
   endtask

   initial begin
      bus.inst_ready     = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 16'h0000;
      test_reset();
      test_backpressure();
      test_redirect_inflight();
      test_wrap_back_to_back();
      test_boot_redirect();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
